// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice and a carry flip-flop process
// WIDTH-bit operands LSB first under a start/busy/done handshake.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cy_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cy_out,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_r;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   res_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;

    logic               bit_s;
    logic               carry_next_s;
    logic [WIDTH-1:0]   res_next_s;
    logic [WIDTH-1:0]   b_cap_s;
    logic               carry_cap_s;

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Full-adder slice plus the operand transform applied at capture (subtract = add ~b with inverted borrow)
    always_comb begin
        bit_s        = a_sh_r[0] ^ b_sh_r[0] ^ carry_r;
        carry_next_s = majority(a_sh_r[0], b_sh_r[0], carry_r);
        res_next_s   = {bit_s, res_r[WIDTH-1:1]};
        b_cap_s      = sub ? ~b : b;
        carry_cap_s  = sub ? ~cy_in : cy_in;
    end

    // Control FSM, serial datapath and registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            res_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cy_out  <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b_cap_s;
                        carry_r <= carry_cap_s;
                        cnt_r   <= '0;
                        res_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
                    res_r   <= res_next_s;
                    carry_r <= carry_next_s;
                    if (cnt_r == LAST_BIT) begin
                        // carry_r is the carry into the MSB stage on this cycle
                        sum     <= res_next_s;
                        cy_out  <= carry_next_s;
                        ovf     <= carry_r ^ carry_next_s;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b_cap_s;
                        carry_r <= carry_cap_s;
                        cnt_r   <= '0;
                        res_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub at WIDTH=8 and WIDTH=16.
module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
    logic [7:0]  a8 = 8'h00, b8 = 8'h00;
    logic        busy8, done8, cy8, ovf8;
    logic [7:0]  sum8;

    logic        start16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = 16'h0000, b16 = 16'h0000;
    logic        busy16, done16, cy16, ovf16;
    logic [15:0] sum16;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  prev_sum8 = 8'h00;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cy_in(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cy_out(cy8), .ovf(ovf8)
    );

    serial_addsub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16), .cy_in(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cy_out(cy16), .ovf(ovf16)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated 8-bit operation; inputs are scrambled after capture
    task automatic op8(input logic s, input logic [7:0] av, input logic [7:0] bv, input logic ci,
                       input logic [7:0] es, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        start8 = 1'b1; sub8 = s; a8 = av; b8 = bv; cin8 = ci;
        @(negedge clk);
        start8 = 1'b0; sub8 = ~s; a8 = ~av; b8 = ~bv; cin8 = ~ci;
        check_eq("sum_hold_in_run", sum8, prev_sum8);
        n = 0;
        while (busy8 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check_eq("busy_cycles", n, 8);
        check_eq("done_pulse", done8, 1'b1);
        check_eq("sum", sum8, es);
        check_eq("cy_out", cy8, ec);
        check_eq("ovf", ovf8, eo);
        prev_sum8 = es;
        @(negedge clk);
        check_eq("done_one_cycle", done8, 1'b0);
        check_eq("idle_busy", busy8, 1'b0);
        check_eq("sum_hold_idle", sum8, es);
    endtask

    // One isolated 16-bit operation
    task automatic op16(input logic s, input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        input logic [15:0] es, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        start16 = 1'b1; sub16 = s; a16 = av; b16 = bv; cin16 = ci;
        @(negedge clk);
        start16 = 1'b0; a16 = 16'h5A5A; b16 = 16'hA5A5;
        n = 0;
        while (busy16 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check_eq("w16_busy_cycles", n, 16);
        check_eq("w16_done", done16, 1'b1);
        check_eq("w16_sum", sum16, es);
        check_eq("w16_cy_out", cy16, ec);
        check_eq("w16_ovf", ovf16, eo);
    endtask

    typedef struct {
        logic       s;
        logic [7:0] av;
        logic [7:0] bv;
        logic       ci;
        logic [7:0] es;
        logic       ec;
        logic       eo;
    } vec_t;

    vec_t b2b[3];

    initial begin
        int n;

        #12;
        check_eq("rst_busy", busy8, 1'b0);
        check_eq("rst_done", done8, 1'b0);
        check_eq("rst_sum", sum8, 8'h00);
        check_eq("rst_cy", cy8, 1'b0);
        check_eq("rst_ovf", ovf8, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        op8(1'b0, 8'h24, 8'h84, 1'b0, 8'hA8, 1'b0, 1'b0);
        op8(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op8(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        op8(1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
        op8(1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);

        // Back-to-back issue with start held high and junk operands during RUN
        b2b[0] = '{1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        b2b[1] = '{1'b1, 8'h10, 8'h20, 1'b1, 8'hEF, 1'b0, 1'b0};
        b2b[2] = '{1'b0, 8'h50, 8'h50, 1'b0, 8'hA0, 1'b0, 1'b1};
        @(negedge clk);
        start8 = 1'b1;
        sub8 = b2b[0].s; a8 = b2b[0].av; b8 = b2b[0].bv; cin8 = b2b[0].ci;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n = 1;
            while (!done8 && n < 20) begin
                a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
                @(negedge clk);
                n++;
            end
            check_eq("b2b_period", n, 9);
            check_eq("b2b_sum", sum8, b2b[k].es);
            check_eq("b2b_cy_out", cy8, b2b[k].ec);
            check_eq("b2b_ovf", ovf8, b2b[k].eo);
            if (k < 2) begin
                sub8 = b2b[k+1].s; a8 = b2b[k+1].av; b8 = b2b[k+1].bv; cin8 = b2b[k+1].ci;
            end else begin
                start8 = 1'b0;
            end
        end
        prev_sum8 = 8'hA0;
        @(negedge clk);
        check_eq("b2b_end_done", done8, 1'b0);

        // Abort an operation mid-flight after a 0xA8 result
        op8(1'b0, 8'h24, 8'h84, 1'b0, 8'hA8, 1'b0, 1'b0);
        @(negedge clk);
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_busy", busy8, 1'b0);
        check_eq("abort_done", done8, 1'b0);
        check_eq("abort_sum", sum8, 8'h00);
        check_eq("abort_cy", cy8, 1'b0);
        check_eq("abort_ovf", ovf8, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        prev_sum8 = 8'h00;
        op8(1'b0, 8'h24, 8'h84, 1'b0, 8'hA8, 1'b0, 1'b0);
        op8(1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);

        op16(1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0);
        op16(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor; successor to the fixed 8-bit serial adder.
- Adds or subtracts two WIDTH-bit operands one bit per clock, LSB first, using a single full-adder slice and a carry flip-flop.
- Adds a start/busy/done handshake, an add/subtract mode, a signed-overflow flag and a result register that holds its value between operations.
- Used by the datapath when area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits; legal range is 2 to 64.
CNT_W, $clog2(WIDTH+1), width of the bit counter; derived, do not override.

Ports:
clk     input   1      rising-edge clock
rst     input   1      asynchronous, active-high reset
start   input   1      request a new operation; sampled only in IDLE or DONE
sub     input   1      0 = add, 1 = subtract; captured with start
a       input   WIDTH  operand A; captured with start
b       input   WIDTH  operand B; captured with start
cy_in   input   1      carry-in (add) or borrow-in (subtract); captured with start
busy    output  1      high while bits are being processed
done    output  1      one-cycle pulse when the result is valid
sum     output  WIDTH  result register
cy_out  output  1      raw carry-out of the MSB stage
ovf     output  1      two's-complement signed overflow

Behaviour:
- Reset:
  - rst=1 forces state IDLE asynchronously.
  - Clears: busy=0, done=0, sum=0, cy_out=0, ovf=0, counter=0, operand shift registers=0, carry FF=0.
  - Reset in the middle of an operation aborts it; no partial result is ever written to sum.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1: capture operands and carry, go to RUN.
  - IDLE, start=0: stay in IDLE.
  - RUN, counter==WIDTH-1: go to DONE.
  - RUN, otherwise: counter increments, stay in RUN.
  - DONE, start=1: capture a new operation, go to RUN (back-to-back issue).
  - DONE, start=0: go to IDLE.
- Capture on the start edge:
  - A_sh <= a.
  - B_sh <= sub ? ~b : b.
  - carry <= sub ? ~cy_in : cy_in.
  - counter <= 0.
  - Internal result shift register cleared.
- Each RUN cycle:
  - s = A_sh[0] ^ B_sh[0] ^ carry.
  - carry <= majority(A_sh[0], B_sh[0], carry).
  - s shifts into the result shift register from the MSB end; A_sh and B_sh shift right by one.
  - On the MSB cycle (counter==WIDTH-1), the carry into the MSB stage is also stored for the overflow calculation.
- Entry to DONE (same edge that leaves RUN):
  - sum <= completed result.
  - cy_out <= final carry.
  - ovf <= carry into MSB ^ carry out of MSB.
- Outputs:
  - sum, cy_out and ovf change only on this edge or on reset. They hold their values during IDLE and during the next RUN.
  - busy=1 exactly while in RUN. done=1 exactly while in DONE, which always lasts one cycle.
- Latency:
  - The start-capture edge is edge 0; done is high after edge WIDTH.
  - Minimum issue interval is WIDTH+1 cycles.
- Subtract semantics:
  - result = a - b - cy_in, modulo 2^WIDTH.
  - cy_out=1 means no borrow; cy_out=0 means borrow.
- Start handling:
  - start is ignored in RUN; inputs must not be re-captured there.
  - a, b, sub and cy_in may change freely after the capture edge.
- Arithmetic is purely modular. No saturation. ovf is meaningful for signed interpretation only.

Test Plan:
- WIDTH=8, add, a=0x24, b=0x84, cy_in=0 -> busy high for 8 cycles; then done pulses for 1 cycle with sum=0xA8, cy_out=0, ovf=0.
- WIDTH=8, add, a=0xFF, b=0x01, cy_in=0 -> sum=0x00, cy_out=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cy_out=0, ovf=1.
- WIDTH=8, sub, a=0x05, b=0x07, cy_in=0 -> sum=0xFE, cy_out=0, ovf=0. Then a=0x80, b=0x01 -> sum=0x7F, cy_out=1, ovf=1.
- Start held high continuously with changing operands -> operations complete every 9 cycles. Operands presented during RUN are ignored, and each sum matches the operands captured at its start edge.
- Assert rst at cycle 4 of an operation that follows a completed result of 0xA8 -> busy, done, sum, cy_out and ovf all go to 0 immediately. A new start afterwards completes correctly.
- WIDTH=16, add, a=0xFFFF, b=0x0001, cy_in=1 -> done after edge 16 with sum=0x0001, cy_out=1, ovf=0.
